// File: rtl/cardinal_input_port.sv
// Ring-router input port: two single-entry VC buffers alternating between
// upstream-facing (external) and arbiter-facing (internal) roles each cycle.
// Optional saturating accept/drop counters: define CARDINAL_INPUT_PORT_STATS_EN.
module cardinal_input_port #(
  parameter int PAC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 polarity,
  input  logic                 in_si,
  output logic                 in_ri,
  input  logic [0:PAC_WIDTH-1] in_di,
  output logic                 req_cw,
  output logic                 req_ccw,
  output logic                 req_pe,
  input  logic                 gnt,
  output logic [0:PAC_WIDTH-1] pkt_out,
  output logic                 vc_err
`ifdef CARDINAL_INPUT_PORT_STATS_EN
  ,
  output logic [15:0]          acc_cnt,
  output logic [15:0]          drop_cnt
`endif
);

  logic                 r_polarity;
  logic [1:0]           r_full;
  logic [0:PAC_WIDTH-1] r_buf [2];
  logic                 r_vc_err;

  logic                 w_ext, w_int;
  logic                 w_hs, w_acc, w_drop, w_pop;
  logic                 w_int_full;
  logic [0:PAC_WIDTH-1] w_int_pkt;
  logic [7:0]           w_hop;

  assign w_ext      = ~r_polarity;
  assign w_int      = r_polarity;
  assign w_int_full = r_full[w_int];
  assign w_int_pkt  = r_buf[w_int];
  assign w_hop      = w_int_pkt[8:15];

  assign in_ri  = ~r_full[w_ext];
  assign w_hs   = in_si & in_ri;
  assign w_acc  = w_hs & (in_di[0] == w_ext);
  assign w_drop = w_hs & (in_di[0] != w_ext);
  // Requests only exist while the internal buffer is full, so this also masks gnt.
  assign w_pop  = w_int_full & gnt;

  assign polarity = r_polarity;
  assign vc_err   = r_vc_err;

  always_comb begin
    req_cw  = 1'b0;
    req_ccw = 1'b0;
    req_pe  = 1'b0;
    pkt_out = '0;
    if (w_int_full) begin
      if (w_hop == 8'd0)            req_pe  = 1'b1;
      else if (w_int_pkt[1] == 1'b0) req_cw  = 1'b1;
      else                           req_ccw = 1'b1;
      pkt_out    = w_int_pkt;
      pkt_out[0] = ~w_int_pkt[0];
      if (w_hop != 8'd0) pkt_out[8:15] = w_hop - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_polarity <= 1'b0;
      r_full     <= 2'b00;
      r_vc_err   <= 1'b0;
    end else begin
      r_polarity <= ~r_polarity;
      // External and internal indices always differ, so both updates land.
      if (w_acc)  r_full[w_ext] <= 1'b1;
      if (w_pop)  r_full[w_int] <= 1'b0;
      if (w_drop) r_vc_err      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_buf[w_ext] <= in_di;
  end

`ifdef CARDINAL_INPUT_PORT_STATS_EN
  logic [15:0] r_acc_cnt, r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_acc  && r_acc_cnt  != 16'hFFFF) r_acc_cnt  <= r_acc_cnt  + 16'd1;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign acc_cnt  = r_acc_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_cardinal_input_port.sv
// Vector-table bench for cardinal_input_port with per-VC scoreboards for pkt_out.
module tb_cardinal_input_port;

  localparam logic [2:0] R_NONE = 3'b000, R_CW = 3'b100, R_CCW = 3'b010, R_PE = 3'b001;
  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        polarity;
  logic        in_si = 1'b0;
  logic        in_ri;
  logic [0:63] in_di = '0;
  logic        req_cw, req_ccw, req_pe;
  logic        gnt = 1'b0;
  logic [0:63] pkt_out;
  logic        vc_err;
`ifdef CARDINAL_INPUT_PORT_STATS_EN
  logic [15:0] acc_cnt, drop_cnt;
`endif

  cardinal_input_port #(.PAC_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .in_si(in_si), .in_ri(in_ri), .in_di(in_di),
    .req_cw(req_cw), .req_ccw(req_ccw), .req_pe(req_pe),
    .gnt(gnt), .pkt_out(pkt_out), .vc_err(vc_err)
`ifdef CARDINAL_INPUT_PORT_STATS_EN
    , .acc_cnt(acc_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       si;
    logic       vc;
    logic       dir;
    logic [7:0] hop;
    logic       gnt;
    logic       ri;
    logic [2:0] req;
    logic       err;
  } vec_t;

  vec_t        vt [NV];
  logic [0:63] q0 [$];
  logic [0:63] q1 [$];
  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  int          n_drop = 0;

  function automatic vec_t mk(logic si, logic vc, logic dir, logic [7:0] hop, logic g,
                              logic ri, logic [2:0] req, logic err);
    vec_t v;
    v.si = si; v.vc = vc; v.dir = dir; v.hop = hop; v.gnt = g;
    v.ri = ri; v.req = req; v.err = err;
    return v;
  endfunction

  function automatic logic [0:63] exp_pkt(logic [0:63] d);
    logic [0:63] o;
    logic [7:0]  h;
    o    = d;
    o[0] = ~d[0];
    h    = d[8:15];
    if (h != 8'd0) o[8:15] = h - 8'd1;
    return o;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(string tag);
    chk({tag, " polarity"}, 64'(polarity), 64'd0);
    chk({tag, " in_ri"},    64'(in_ri),    64'd1);
    chk({tag, " req"},      64'({req_cw, req_ccw, req_pe}), 64'(R_NONE));
    chk({tag, " pkt_out"},  64'(pkt_out),  64'd0);
    chk({tag, " vc_err"},   64'(vc_err),   64'd0);
  endtask

  initial begin
    logic        pol, acc;
    logic [0:63] d, front;
    string       tag;

    vt[0]  = mk(1, 1, 0, 8'd3,   0, 1, R_NONE, 0);
    vt[1]  = mk(1, 0, 0, 8'd0,   1, 1, R_CW,   0);
    vt[2]  = mk(1, 1, 1, 8'd5,   1, 1, R_PE,   0);
    vt[3]  = mk(0, 0, 0, 8'd0,   0, 1, R_CCW,  0);
    vt[4]  = mk(1, 1, 0, 8'd7,   0, 0, R_NONE, 0);
    vt[5]  = mk(0, 0, 0, 8'd0,   1, 1, R_CCW,  0);
    vt[6]  = mk(1, 0, 0, 8'd4,   0, 1, R_NONE, 0);
    vt[7]  = mk(0, 0, 0, 8'd0,   1, 1, R_NONE, 1);
    vt[8]  = mk(1, 1, 0, 8'd1,   1, 1, R_NONE, 1);
    vt[9]  = mk(1, 0, 1, 8'd2,   1, 1, R_CW,   1);
    vt[10] = mk(1, 1, 0, 8'd0,   1, 1, R_CCW,  1);
    vt[11] = mk(1, 0, 0, 8'd255, 1, 1, R_PE,   1);
    vt[12] = mk(1, 1, 1, 8'd1,   1, 1, R_CW,   1);
    vt[13] = mk(0, 0, 0, 8'd0,   1, 1, R_CCW,  1);
    vt[14] = mk(0, 0, 0, 8'd0,   0, 1, R_NONE, 1);
    vt[15] = mk(1, 0, 0, 8'd2,   0, 1, R_NONE, 1);
    vt[16] = mk(1, 1, 1, 8'd3,   0, 1, R_CW,   1);
    vt[17] = mk(0, 0, 0, 8'd0,   0, 0, R_CCW,  1);

    @(negedge clk);
    chk_idle("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      pol   = 1'(i % 2);
      d     = {vt[i].vc, vt[i].dir, 6'b0, vt[i].hop, 16'h0, $urandom()};
      in_si = vt[i].si;
      in_di = d;
      gnt   = vt[i].gnt;
      #2;
      tag = $sformatf("v%0d", i);
      chk({tag, " polarity"}, 64'(polarity), 64'(pol));
      chk({tag, " in_ri"},    64'(in_ri),    64'(vt[i].ri));
      chk({tag, " req"},      64'({req_cw, req_ccw, req_pe}), 64'(vt[i].req));
      chk({tag, " vc_err"},   64'(vc_err),   64'(vt[i].err));
      // The internal buffer's VC equals polarity; check the offered packet against it.
      if (req_cw | req_ccw | req_pe) begin
        if ((pol ? q1.size() : q0.size()) == 0) begin
          chk({tag, " scoreboard entry present"}, 64'd0, 64'd1);
        end else begin
          front = pol ? q1[0] : q0[0];
          chk({tag, " pkt_out"}, 64'(pkt_out), 64'(front));
          if (vt[i].gnt) begin
            if (pol) void'(q1.pop_front());
            else     void'(q0.pop_front());
          end
        end
      end else begin
        chk({tag, " pkt_out idle"}, 64'(pkt_out), 64'd0);
      end
      acc = vt[i].si && vt[i].ri && (vt[i].vc == ~pol);
      if (acc) begin
        n_acc++;
        if (vt[i].vc) q1.push_back(exp_pkt(d));
        else          q0.push_back(exp_pkt(d));
      end else if (vt[i].si && vt[i].ri) begin
        n_drop++;
      end
    end

`ifdef CARDINAL_INPUT_PORT_STATS_EN
    chk("acc_cnt",  64'(acc_cnt),  64'(n_acc));
    chk("drop_cnt", 64'(drop_cnt), 64'(n_drop));
`endif

    // Reset with both buffers full: everything clears without waiting for an edge.
    #1;
    reset = 1'b1;
    in_si = 1'b1;
    in_di = {1'b1, 1'b0, 6'b0, 8'd2, 48'h0};
    gnt   = 1'b0;
    #1;
    chk_idle("async reset");
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    in_si = 1'b0;
    #2;
    chk_idle("post reset c0");
    @(negedge clk);
    #2;
    chk("post reset c1 polarity", 64'(polarity), 64'd1);
    chk("post reset c1 req",      64'({req_cw, req_ccw, req_pe}), 64'(R_NONE));
`ifdef CARDINAL_INPUT_PORT_STATS_EN
    chk("post reset acc_cnt", 64'(acc_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cardinal_input_port.md
CARDINAL_INPUT_PORT -- requirements
Module: cardinal_input_port

Interface
REQ-001 The block SHALL have parameter PAC_WIDTH, default 64, giving the packet width in bits (MSB-first indexing [0:PAC_WIDTH-1]).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port polarity, output, 1 bit: the router polarity, also driven to the attached NIC.
REQ-005 The block SHALL have port in_si, input, 1 bit: upstream send handshake.
REQ-006 The block SHALL have port in_ri, output, 1 bit: ready handshake to upstream.
REQ-007 The block SHALL have port in_di, input, PAC_WIDTH bits: upstream packet.
REQ-008 The block SHALL have ports req_cw, req_ccw and req_pe, each output, 1 bit: forwarding request to the clockwise, counter-clockwise and local-PE output.
REQ-009 The block SHALL have port gnt, input, 1 bit: grant from the output arbiter for the current request.
REQ-010 The block SHALL have port pkt_out, output, PAC_WIDTH bits: packet offered with the request.
REQ-011 The block SHALL have port vc_err, output, 1 bit: sticky VC-mismatch flag.

Function
REQ-012 Packet fields SHALL be: [0] VC, [1] dir (0=cw, 1=ccw), [2:7] reserved, [8:15] hop count (unsigned), [16:PAC_WIDTH-1] passed unmodified.
REQ-013 polarity SHALL be a register toggling every cycle after reset.
REQ-014 The block SHALL hold two one-entry buffers, VC0 and VC1, each with a full bit.
REQ-015 External VC SHALL be ~polarity; internal VC SHALL be polarity.
REQ-016 in_ri SHALL be ~full of the external VC buffer, combinationally.
REQ-017 When in_si & in_ri and in_di[0] equals the external VC, the packet SHALL be written into that buffer, which becomes full at the next edge.
REQ-018 When in_si & in_ri and in_di[0] does not equal the external VC, the packet SHALL be dropped and vc_err set at the next edge; vc_err stays high until reset.
REQ-019 When the internal VC buffer is full, exactly one request SHALL assert combinationally: req_pe if hop==0, else req_cw if dir==0, else req_ccw. All requests SHALL be 0 when it is empty.
REQ-020 pkt_out SHALL be the internal buffer content with bit [0] inverted; when hop!=0, hop SHALL be decremented by 1 (no wrap, since hop!=0). When hop==0, hop SHALL be unchanged. pkt_out SHALL be all-zero when no request is asserted.
REQ-021 On request & gnt, the internal buffer SHALL clear at the next edge. Without gnt it SHALL hold, re-requesting when polarity next selects it (two cycles later).
REQ-022 gnt SHALL be ignored when no request is asserted.
REQ-023 A write to the external VC and a pop of the internal VC in the same cycle SHALL both complete, since they target different buffers.
REQ-024 Minimum latency from accepted write to request SHALL be 1 cycle, on the next cycle, when polarity has flipped.

Reset
REQ-025 On reset, polarity, both full bits, vc_err and any stats counters SHALL clear to 0 immediately. As a result, in_ri=1, all req_*=0 and pkt_out=0.
REQ-026 Reset mid-operation SHALL discard buffered packets. A handshake in the reset cycle SHALL be ignored.
REQ-027 After reset deasserts, the first cycle SHALL have polarity=0, external VC=1.

Configuration
REQ-028 With macro CARDINAL_INPUT_PORT_STATS_EN defined, the block SHALL add outputs acc_cnt and drop_cnt, each 16 bits. They count accepted writes and VC-mismatch drops, and saturate at 16'hFFFF.
REQ-029 Without CARDINAL_INPUT_PORT_STATS_EN, those ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: reset, then with polarity=0 send in_di VC=1, dir=0, hop=3 -> next cycle req_cw=1, and pkt_out has VC=0, hop=2; with gnt=1, the buffer empties.
REQ-031 Scenario: packet with hop=0 accepted -> req_pe=1 next cycle, and pkt_out hop=0.
REQ-032 Scenario: with polarity=1, send VC=1 -> packet dropped, vc_err=1 and stays 1; no request follows; drop_cnt=1 with the macro defined.
REQ-033 Scenario: hold gnt=0 with the buffer full -> req_ccw toggles 1,0,1 with polarity; in_ri=0 in cycles where that VC is external; with gnt=1, the buffer clears.
REQ-034 Scenario: back-to-back writes every cycle with gnt=1 -> a write and a pop occur in the same cycle, with no loss; acc_cnt equals the number sent.
REQ-035 Scenario: assert reset while both buffers are full -> requests drop in the same cycle, in_ri=1, polarity=0.
